// File: rtl/rx_event_monitor_pkg.sv
// rx_event_monitor_pkg: shared state encodings, register index and event indices for the rx event monitor
package rx_event_monitor_pkg;
  typedef enum logic [1:0] {
    MON_S_RUN     = 2'd0,
    MON_S_REQ     = 2'd1,
    MON_S_HOLDOFF = 2'd2
  } mon_state_e;
  localparam logic [4:0] MON_CLR_ADDR = 5'd17;
  localparam int EVT_SHORT_FAIL = 0;
  localparam int EVT_LONG_FAIL  = 1;
  localparam int EVT_SIG_FAIL   = 2;
  localparam int EVT_FCS_FAIL   = 3;
  localparam int EVT_FCS_OK     = 4;
  localparam int EVT_WDOG       = 5;
  localparam int EVT_HT_UNSUP   = 6;
  localparam int EVT_PHASE_TH   = 7;
endpackage

// File: rtl/rx_event_counter_ch.sv
// rx_event_counter_ch: event select mux, saturating live counter and result latch for one channel
module rx_event_counter_ch #(
  parameter int NUM_EVT = 8,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] event_vec_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               clr_i,
  input  logic               restart_i,
  input  logic               latch_i,
  input  logic               cum_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [CNT_W-1:0]   nxt_o,
  output logic               changed_o
);
  localparam int EW = 1 << SEL_W;
  logic [EW-1:0]    evt_pad;
  logic             hit;
  logic [CNT_W-1:0] live_q, live_d, live_inc, cnt_q, cnt_d;
  // zero-padding the event vector makes out-of-range selectors read a constant 0
  assign evt_pad   = EW'(event_vec_i);
  assign hit       = evt_pad[sel_i];
  assign live_inc  = (hit && live_q != '1) ? live_q + 1'b1 : live_q;
  assign live_d    = (clr_i || restart_i || latch_i) ? '0 : live_inc;
  assign cnt_d     = clr_i ? '0 : latch_i ? live_inc : cum_i ? live_d : cnt_q;
  assign changed_o = live_d != live_q;
  assign nxt_o     = cnt_d;
  assign cnt_o     = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
      cnt_q  <= '0;
    end else begin
      live_q <= live_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/rx_event_monitor.sv
// rx_event_monitor: multi-channel rx event counters with windowing, alarm threshold and held-off reset request
module rx_event_monitor
  import rx_event_monitor_pkg::*;
#(
  parameter int         NUM_EVT  = 8,
  parameter int         NUM_CH   = 4,
  parameter int         SEL_W    = 3,
  parameter int         CNT_W    = 22,
  parameter int         WIN_W    = 24,
  parameter logic [4:0] CLR_ADDR = MON_CLR_ADDR
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic [NUM_EVT-1:0]      event_vec,
  input  logic [NUM_CH*SEL_W-1:0] event_sel,
  input  logic                    win_mode,
  input  logic [WIN_W-1:0]        win_len,
  input  logic [NUM_CH-1:0]       alarm_en,
  input  logic [CNT_W-1:0]        alarm_th,
  input  logic [WIN_W-1:0]        holdoff_len,
  input  logic                    slv_reg_wren_signal,
  input  logic [4:0]              axi_awaddr_core,
  output logic [NUM_CH*CNT_W-1:0] cnt_out,
  output logic                    cnt_valid,
  output logic [NUM_CH-1:0]       alarm_ch,
  output logic                    rst_req
);
  logic                    clr, mode_chg, latch, mode_q, cnt_valid_q, rst_req_q;
  logic [WIN_W-1:0]        win_q, win_d, win_last, hold_q, hold_nxt;
  logic [NUM_CH-1:0]       changed, hits, alarm_ch_q;
  logic [NUM_CH*CNT_W-1:0] nxt;
  mon_state_e              state_q;
  assign clr      = slv_reg_wren_signal && axi_awaddr_core == CLR_ADDR;
  assign mode_chg = win_mode != mode_q;
  assign win_last = (win_len == '0) ? '0 : win_len - 1'b1;
  // >= rather than == so a shrinking win_len mid-window closes the window instead of wrapping
  assign latch    = win_mode && tick && !clr && !mode_chg && win_q >= win_last;
  assign win_d    = (clr || mode_chg || !win_mode) ? '0 : !tick ? win_q : latch ? '0 : win_q + 1'b1;
  assign hold_nxt = hold_q + WIN_W'(tick);
  genvar k;
  for (k = 0; k < NUM_CH; k++) begin : g_ch
    rx_event_counter_ch #(.NUM_EVT(NUM_EVT), .SEL_W(SEL_W), .CNT_W(CNT_W)) u_ch (
      .clk        (clock),
      .rst        (reset),
      .event_vec_i(event_vec),
      .sel_i      (event_sel[k*SEL_W +: SEL_W]),
      .clr_i      (clr),
      .restart_i  (mode_chg),
      .latch_i    (latch),
      .cum_i      (!win_mode),
      .cnt_o      (cnt_out[k*CNT_W +: CNT_W]),
      .nxt_o      (nxt[k*CNT_W +: CNT_W]),
      .changed_o  (changed[k])
    );
    assign hits[k] = alarm_en[k] && alarm_th != '0 && nxt[k*CNT_W +: CNT_W] >= alarm_th;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q      <= 1'b0;
      win_q       <= '0;
      hold_q      <= '0;
      alarm_ch_q  <= '0;
      cnt_valid_q <= 1'b0;
      rst_req_q   <= 1'b0;
      state_q     <= MON_S_RUN;
    end else begin
      mode_q      <= win_mode;
      win_q       <= win_d;
      cnt_valid_q <= clr || latch || (!win_mode && |changed);
      rst_req_q   <= 1'b0;
      if (clr) alarm_ch_q <= '0;
      case (state_q)
        MON_S_RUN: if (latch && |hits) begin
          state_q    <= MON_S_REQ;
          alarm_ch_q <= hits;
          rst_req_q  <= 1'b1;
        end
        MON_S_REQ: begin
          state_q <= MON_S_HOLDOFF;
          hold_q  <= '0;
        end
        default: if (holdoff_len == '0 || hold_nxt >= holdoff_len) state_q <= MON_S_RUN;
                 else hold_q <= hold_nxt;
      endcase
    end
  end
  assign cnt_valid = cnt_valid_q;
  assign alarm_ch  = alarm_ch_q;
  assign rst_req   = rst_req_q;
endmodule

// File: tb/tb_rx_event_monitor.sv
// tb_rx_event_monitor: scoreboard bench for rx_event_monitor (NUM_EVT=6, CNT_W=4 to reach saturation and bad selectors)
module tb_rx_event_monitor;
  import rx_event_monitor_pkg::*;
  localparam int NE = 6, NC = 4, SW = 3, CW = 4, WW = 24;
  logic              clock = 1'b0;
  logic              reset, tick, win_mode, slv_reg_wren_signal, cnt_valid, rst_req;
  logic [NE-1:0]     event_vec;
  logic [NC*SW-1:0]  event_sel;
  logic [WW-1:0]     win_len, holdoff_len;
  logic [NC-1:0]     alarm_en, alarm_ch;
  logic [CW-1:0]     alarm_th;
  logic [4:0]        axi_awaddr_core;
  logic [NC*CW-1:0]  cnt_out;
  logic [NC*CW-1:0]  exp_q[$];
  int                vectors = 0, miscompares = 0, nvalid = 0, nreq = 0;

  rx_event_monitor #(.NUM_EVT(NE), .NUM_CH(NC), .SEL_W(SW), .CNT_W(CW), .WIN_W(WW), .CLR_ADDR(5'd17)) dut (
    .clock(clock), .reset(reset), .tick(tick), .event_vec(event_vec), .event_sel(event_sel),
    .win_mode(win_mode), .win_len(win_len), .alarm_en(alarm_en), .alarm_th(alarm_th),
    .holdoff_len(holdoff_len), .slv_reg_wren_signal(slv_reg_wren_signal),
    .axi_awaddr_core(axi_awaddr_core), .cnt_out(cnt_out), .cnt_valid(cnt_valid),
    .alarm_ch(alarm_ch), .rst_req(rst_req)
  );

  always #5 clock = ~clock;

  function automatic logic [NC*CW-1:0] pk(int c0, int c1, int c2, int c3);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  function automatic logic [NC*SW-1:0] sel(int s0, int s1, int s2, int s3);
    return {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
  endfunction

  task automatic cyc();
    logic [NC*CW-1:0] e;
    @(posedge clock);
    #1;
    if (rst_req) nreq++;
    if (cnt_valid) begin
      nvalid++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard: unexpected cnt_valid with cnt_out=%h, required no pulse", cnt_out);
      end else begin
        e = exp_q.pop_front();
        if (cnt_out !== e) begin
          miscompares++;
          $display("FAIL scoreboard: cnt_out=%h required %h", cnt_out, e);
        end
      end
    end
  endtask

  task automatic drain(string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: %0d expected updates never seen, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic clear_write();
    slv_reg_wren_signal = 1'b1;
    axi_awaddr_core = 5'd17;
    exp_q.push_back(pk(0, 0, 0, 0));
    cyc();
    slv_reg_wren_signal = 1'b0;
    axi_awaddr_core = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; event_vec = '0; win_mode = 1'b0; win_len = '0;
    alarm_en = '0; alarm_th = '0; holdoff_len = '0; slv_reg_wren_signal = 1'b0; axi_awaddr_core = '0;
    event_sel = sel(EVT_SIG_FAIL, EVT_FCS_FAIL, EVT_FCS_OK, EVT_WDOG);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    vectors += 4;
    if (cnt_out !== '0) begin miscompares++; $display("FAIL reset cnt_out: %h required 0", cnt_out); end
    if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL reset cnt_valid: %b required 0", cnt_valid); end
    if (alarm_ch !== '0) begin miscompares++; $display("FAIL reset alarm_ch: %b required 0", alarm_ch); end
    if (rst_req !== 1'b0) begin miscompares++; $display("FAIL reset rst_req: %b required 0", rst_req); end
  endtask

  task automatic test_cumulative();
    for (int i = 1; i <= 10; i++) begin
      event_vec = 6'b000100;
      exp_q.push_back(pk(i, 0, 0, 0));
      cyc();
      event_vec = '0;
      if (i > 5) cyc();
    end
    vectors += 2;
    if (cnt_out !== pk(10, 0, 0, 0)) begin miscompares++; $display("FAIL cum_ten: cnt_out=%h required %h", cnt_out, pk(10, 0, 0, 0)); end
    if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL cum_idle_valid: %b required 0", cnt_valid); end
    event_vec = 6'b101000;
    exp_q.push_back(pk(10, 1, 0, 1));
    cyc();
    event_vec = 6'b010000;
    exp_q.push_back(pk(10, 1, 1, 1));
    cyc();
    event_vec = '0;
    cyc();
    vectors++;
    if (cnt_out !== pk(10, 1, 1, 1)) begin miscompares++; $display("FAIL cum_multi: cnt_out=%h required %h", cnt_out, pk(10, 1, 1, 1)); end
    drain("cumulative");
  endtask

  task automatic test_saturation();
    clear_write();
    for (int i = 1; i <= 20; i++) begin
      event_vec = 6'b000100;
      if (i <= 15) exp_q.push_back(pk(i, 0, 0, 0));
      cyc();
    end
    event_vec = '0;
    cyc();
    vectors += 2;
    if (cnt_out !== pk(15, 0, 0, 0)) begin miscompares++; $display("FAIL saturate: cnt_out=%h required %h", cnt_out, pk(15, 0, 0, 0)); end
    if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL saturate_valid: %b required 0", cnt_valid); end
    clear_write();
    vectors += 2;
    if (cnt_valid !== 1'b1) begin miscompares++; $display("FAIL clear_valid: %b required 1", cnt_valid); end
    if (cnt_out !== '0) begin miscompares++; $display("FAIL clear_cnt: %h required 0", cnt_out); end
    slv_reg_wren_signal = 1'b1;
    axi_awaddr_core = 5'd16;
    event_vec = 6'b000100;
    exp_q.push_back(pk(1, 0, 0, 0));
    cyc();
    slv_reg_wren_signal = 1'b0;
    axi_awaddr_core = '0;
    event_vec = '0;
    drain("saturation");
  endtask

  task automatic test_clear_collision();
    for (int i = 2; i <= 3; i++) begin
      event_vec = 6'b000100;
      exp_q.push_back(pk(i, 0, 0, 0));
      cyc();
    end
    event_vec = 6'b000100;
    clear_write();
    event_vec = '0;
    vectors++;
    if (cnt_out !== '0) begin miscompares++; $display("FAIL collide: cnt_out=%h required 0", cnt_out); end
    cyc();
    vectors += 2;
    if (cnt_out !== '0) begin miscompares++; $display("FAIL collide_after: cnt_out=%h required 0", cnt_out); end
    if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL collide_valid: %b required 0", cnt_valid); end
    drain("collision");
  endtask

  task automatic test_bad_sel();
    event_sel = sel(EVT_SIG_FAIL, EVT_FCS_FAIL, EVT_PHASE_TH, EVT_WDOG);
    for (int i = 1; i <= 3; i++) begin
      event_vec = '1;
      exp_q.push_back(pk(i, i, 0, i));
      cyc();
    end
    event_sel = sel(EVT_SIG_FAIL, EVT_FCS_FAIL, EVT_HT_UNSUP, EVT_WDOG);
    exp_q.push_back(pk(4, 4, 0, 4));
    cyc();
    event_vec = '0;
    cyc();
    vectors++;
    if (cnt_out[2*CW +: CW] !== '0) begin miscompares++; $display("FAIL bad_sel: ch2=%0d required 0", cnt_out[2*CW +: CW]); end
    clear_write();
    drain("bad_sel");
  endtask

  task automatic test_windowed();
    int nv0, nr0;
    win_mode = 1'b1;
    win_len = 24'd100;
    tick = 1'b0;
    cyc();
    nv0 = nvalid;
    nr0 = nreq;
    tick = 1'b1;
    for (int j = 1; j <= 200; j++) begin
      event_vec = ((j % 10 == 0 && j <= 60) || j == 100 || j == 150 || j == 199) ? 6'b000100 : 6'b0;
      if (j == 100) exp_q.push_back(pk(7, 0, 0, 0));
      if (j == 200) exp_q.push_back(pk(2, 0, 0, 0));
      cyc();
      if (j == 150) begin
        vectors++;
        if (cnt_out !== pk(7, 0, 0, 0)) begin miscompares++; $display("FAIL win_hold: cnt_out=%h required %h", cnt_out, pk(7, 0, 0, 0)); end
      end
    end
    event_vec = '0;
    tick = 1'b0;
    cyc();
    vectors += 2;
    if (nvalid - nv0 != 2) begin miscompares++; $display("FAIL win_valid_count: %0d pulses required 2", nvalid - nv0); end
    if (nreq != nr0) begin miscompares++; $display("FAIL win_no_alarm: %0d requests required 0", nreq - nr0); end
    drain("windowed");
    clear_write();
    drain("windowed_clear");
  endtask

  task automatic test_alarm();
    int reqs[$];
    alarm_th = 4'd5;
    alarm_en = 4'b0010;
    holdoff_len = 24'd250;
    tick = 1'b1;
    for (int j = 1; j <= 420; j++) begin
      event_vec = (j % 100 >= 5 && j % 100 <= 55 && j % 10 == 5) ? 6'b001000 : 6'b0;
      if (j % 100 == 0) exp_q.push_back(pk(0, 6, 0, 0));
      cyc();
      if (rst_req) reqs.push_back(j);
      if (j == 100) begin
        vectors++;
        if (alarm_ch !== 4'b0010) begin miscompares++; $display("FAIL alarm_ch: %b required 0010", alarm_ch); end
      end
    end
    event_vec = '0;
    vectors += 3;
    if (reqs.size() != 2) begin miscompares++; $display("FAIL alarm_req_count: %0d required 2", reqs.size()); end
    if (reqs.size() < 1 || reqs[0] != 100) begin miscompares++; $display("FAIL alarm_first: cycle %0d required 100", reqs.size() > 0 ? reqs[0] : -1); end
    if (reqs.size() < 2 || reqs[1] != 400) begin miscompares++; $display("FAIL alarm_second: cycle %0d required 400", reqs.size() > 1 ? reqs[1] : -1); end
    vectors++;
    if (alarm_ch !== 4'b0010) begin miscompares++; $display("FAIL alarm_sticky: %b required 0010", alarm_ch); end
    drain("alarm");
  endtask

  task automatic test_reset_holdoff();
    int reqs[$];
    reset = 1'b1;
    cyc();
    vectors += 4;
    if (cnt_out !== '0) begin miscompares++; $display("FAIL rst_hold cnt_out: %h required 0", cnt_out); end
    if (cnt_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold cnt_valid: %b required 0", cnt_valid); end
    if (alarm_ch !== '0) begin miscompares++; $display("FAIL rst_hold alarm_ch: %b required 0", alarm_ch); end
    if (rst_req !== 1'b0) begin miscompares++; $display("FAIL rst_hold rst_req: %b required 0", rst_req); end
    reset = 1'b0;
    tick = 1'b0;
    cyc();
    tick = 1'b1;
    for (int j = 1; j <= 100; j++) begin
      event_vec = (j >= 5 && j <= 55 && j % 10 == 5) ? 6'b001000 : 6'b0;
      if (j == 100) exp_q.push_back(pk(0, 6, 0, 0));
      cyc();
      if (rst_req) reqs.push_back(j);
    end
    event_vec = '0;
    tick = 1'b0;
    vectors++;
    if (reqs.size() != 1 || reqs[0] != 100) begin miscompares++; $display("FAIL rst_hold run: %0d requests, first at %0d, required 1 at 100", reqs.size(), reqs.size() > 0 ? reqs[0] : -1); end
    drain("reset_holdoff");
  endtask

  initial begin
    test_reset();
    test_cumulative();
    test_saturation();
    test_clear_collision();
    test_bad_sel();
    test_windowed();
    test_alarm();
    test_reset_holdoff();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
